// File: rtl/udp_16_to_32bit_if.sv
// rtl/udp_16_to_32bit_if.sv - halfword ingress and UDP TX word handshake bundle
interface udp_16_to_32bit_if;
  logic        data_en_16;
  logic [15:0] data_16;
  logic        data_last;
  logic        data_ready;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req;
  logic [31:0] tx_data;
  logic        udp_tx_done;
  logic        overflow;

  modport master (
    output data_en_16, data_16, data_last, tx_req, udp_tx_done,
    input  data_ready, tx_start_en, tx_byte_num, tx_data, overflow
  );

  modport slave (
    input  data_en_16, data_16, data_last, tx_req, udp_tx_done,
    output data_ready, tx_start_en, tx_byte_num, tx_data, overflow
  );
endinterface

// File: rtl/udp_16_to_32bit.sv
// rtl/udp_16_to_32bit.sv - packs 16-bit halfwords into a one-packet 32-bit buffer for UDP TX
module udp_16_to_32bit #(
  parameter int MAX_WORDS = 256,
  parameter int AW        = 8
) (
  input logic               eth_tx_clk,
  input logic               rst,
  udp_16_to_32bit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FILL, START, SEND} state_t;

  // Halfword count at which a packet closes on its own (buffer full).
  localparam logic [AW+1:0] HMAX = (AW+2)'(2 * MAX_WORDS);

  state_t          state_q, state_d;
  logic [15:0]     hold_q, hold_d;
  logic            half_q, half_d;
  logic [AW+1:0]   hcnt_q, hcnt_d;
  logic [AW:0]     wr_cnt_q, wr_cnt_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [15:0]     byte_num_q, byte_num_d;
  logic [31:0]     tx_data_q, tx_data_d;
  logic            overflow_q, overflow_d;

  logic [31:0]     mem_q [MAX_WORDS];
  logic            wr_en;
  logic [31:0]     wr_word;
  logic            data_ready;
  logic            close;

  // Next-state, packing, close detection and read path.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    half_d     = half_q;
    hcnt_d     = hcnt_q;
    wr_cnt_d   = wr_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    byte_num_d = byte_num_q;
    tx_data_d  = tx_data_q;
    wr_en      = 1'b0;
    wr_word    = '0;
    close      = 1'b0;
    data_ready = (state_q == IDLE) || (state_q == FILL);
    overflow_d = bus.data_en_16 && !data_ready;

    case (state_q)
      IDLE, FILL: begin
        if (bus.data_en_16) begin
          hcnt_d = hcnt_q + 1'b1;
          close  = bus.data_last || (hcnt_d == HMAX);
          if (half_q) begin
            wr_en   = 1'b1;
            wr_word = {hold_q, bus.data_16};
            half_d  = 1'b0;
          end else if (close) begin
            // Odd-length close: flush the lone high half with a zero low half.
            wr_en   = 1'b1;
            wr_word = {bus.data_16, 16'h0000};
          end else begin
            hold_d = bus.data_16;
            half_d = 1'b1;
          end
          if (wr_en) wr_cnt_d = wr_cnt_q + 1'b1;
          if (close) begin
            byte_num_d = 16'({hcnt_d, 1'b0});
            state_d    = START;
          end else begin
            state_d = FILL;
          end
        end
      end
      START: state_d = SEND;
      SEND: begin
        if (bus.tx_req) begin
          if (rd_ptr_q < wr_cnt_q) begin
            tx_data_d = mem_q[rd_ptr_q[AW-1:0]];
            rd_ptr_d  = rd_ptr_q + 1'b1;
          end else begin
            tx_data_d = '0;
          end
        end
        if (bus.udp_tx_done) begin
          state_d  = IDLE;
          rd_ptr_d = '0;
          wr_cnt_d = '0;
          hcnt_d   = '0;
          half_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge eth_tx_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      half_q     <= 1'b0;
      hcnt_q     <= '0;
      wr_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      byte_num_q <= '0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      half_q     <= half_d;
      hcnt_q     <= hcnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_num_q <= byte_num_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Packet buffer; contents are only meaningful below wr_cnt, so no reset.
  always_ff @(posedge eth_tx_clk) begin
    if (wr_en && !rst) mem_q[wr_cnt_q[AW-1:0]] <= wr_word;
  end

  assign bus.data_ready  = data_ready;
  assign bus.tx_start_en = (state_q == START);
  assign bus.tx_byte_num = byte_num_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_udp_16_to_32bit.sv
// tb/tb_udp_16_to_32bit.sv - scoreboard bench for the 16-to-32 bit UDP packer
module tb_udp_16_to_32bit;
  logic eth_tx_clk = 1'b0;
  logic rst = 1'b1;
  always #5 eth_tx_clk = ~eth_tx_clk;

  udp_16_to_32bit_if bus();

  udp_16_to_32bit #(.MAX_WORDS(256), .AW(8)) dut (
    .eth_tx_clk (eth_tx_clk),
    .rst        (rst),
    .bus        (bus)
  );

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int ovf_cnt = 0;
  logic [31:0] exp_q [$];

  // Count output pulses a little after each rising edge.
  always @(posedge eth_tx_clk) begin
    #2;
    if (bus.tx_start_en) start_cnt++;
    if (bus.overflow) ovf_cnt++;
  end

  task automatic hw(input logic [15:0] d, input logic l);
    bus.data_en_16 = 1'b1;
    bus.data_16    = d;
    bus.data_last  = l;
    @(negedge eth_tx_clk);
    bus.data_en_16 = 1'b0;
    bus.data_last  = 1'b0;
  endtask

  task automatic req(output logic [31:0] w);
    bus.tx_req = 1'b1;
    @(negedge eth_tx_clk);
    bus.tx_req = 1'b0;
    w = bus.tx_data;
  endtask

  task automatic wait_start(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_start_en) begin
        ok = 1'b1;
        break;
      end
      @(negedge eth_tx_clk);
    end
    @(negedge eth_tx_clk);
  endtask

  task automatic done_pkt();
    bus.udp_tx_done = 1'b1;
    @(negedge eth_tx_clk);
    bus.udp_tx_done = 1'b0;
  endtask

  task automatic test_reset();
    bus.data_en_16 = 0; bus.data_16 = 0; bus.data_last = 0;
    bus.tx_req = 0; bus.udp_tx_done = 0;
    rst = 1'b1;
    repeat (3) @(negedge eth_tx_clk);
    checks++; if (bus.data_ready !== 1'b1) begin failures++; $display("FAIL reset_data_ready got=%b exp=1", bus.data_ready); end
    checks++; if (bus.tx_start_en !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", bus.tx_start_en); end
    checks++; if (bus.tx_byte_num !== 16'd0) begin failures++; $display("FAIL reset_byte_num got=%0d exp=0", bus.tx_byte_num); end
    checks++; if (bus.tx_data !== 32'd0) begin failures++; $display("FAIL reset_tx_data got=%h exp=0", bus.tx_data); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    rst = 1'b0;
    @(negedge eth_tx_clk);
  endtask

  task automatic test_even();
    int s0; logic ok; logic [31:0] w, e;
    s0 = start_cnt;
    exp_q.push_back(32'h11112222);
    exp_q.push_back(32'h33334444);
    hw(16'h1111, 0); hw(16'h2222, 0); hw(16'h3333, 0); hw(16'h4444, 1);
    wait_start(ok);
    checks++; if (!ok) begin failures++; $display("FAIL even_start_timeout got=0 exp=1"); end
    checks++; if (bus.tx_byte_num !== 16'd8) begin failures++; $display("FAIL even_byte_num got=%0d exp=8", bus.tx_byte_num); end
    for (int i = 0; i < 2; i++) begin
      req(w); e = exp_q.pop_front();
      checks++; if (w !== e) begin failures++; $display("FAIL even_word%0d got=%h exp=%h", i, w, e); end
    end
    checks++; if (start_cnt !== s0 + 1) begin failures++; $display("FAIL even_start_pulses got=%0d exp=1", start_cnt - s0); end
    bus.udp_tx_done = 1'b1;
    checks++; if (bus.data_ready !== 1'b0) begin failures++; $display("FAIL even_ready_in_send got=%b exp=0", bus.data_ready); end
    @(negedge eth_tx_clk);
    bus.udp_tx_done = 1'b0;
    checks++; if (bus.data_ready !== 1'b1) begin failures++; $display("FAIL even_ready_after_done got=%b exp=1", bus.data_ready); end
    checks++; if (bus.tx_byte_num !== 16'd8) begin failures++; $display("FAIL even_byte_num_hold got=%0d exp=8", bus.tx_byte_num); end
  endtask

  task automatic test_odd();
    logic ok; logic [31:0] w, e;
    exp_q.push_back(32'hAAAABBBB);
    exp_q.push_back(32'hCCCC0000);
    exp_q.push_back(32'h00000000);
    hw(16'hAAAA, 0); hw(16'hBBBB, 0); hw(16'hCCCC, 1);
    wait_start(ok);
    checks++; if (!ok) begin failures++; $display("FAIL odd_start_timeout got=0 exp=1"); end
    checks++; if (bus.tx_byte_num !== 16'd6) begin failures++; $display("FAIL odd_byte_num got=%0d exp=6", bus.tx_byte_num); end
    for (int i = 0; i < 3; i++) begin
      req(w); e = exp_q.pop_front();
      checks++; if (w !== e) begin failures++; $display("FAIL odd_word%0d got=%h exp=%h", i, w, e); end
    end
    done_pkt();
  endtask

  task automatic test_full();
    int s0; logic ok; logic [31:0] w, e;
    s0 = start_cnt;
    for (int k = 0; k < 256; k++) exp_q.push_back({16'(2 * k), 16'(2 * k + 1)});
    for (int i = 0; i < 511; i++) hw(16'(i), 0);
    checks++; if (start_cnt !== s0) begin failures++; $display("FAIL full_early_start got=%0d exp=0", start_cnt - s0); end
    checks++; if (bus.data_ready !== 1'b1) begin failures++; $display("FAIL full_ready_before_last got=%b exp=1", bus.data_ready); end
    hw(16'd511, 0);
    wait_start(ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_start_timeout got=0 exp=1"); end
    checks++; if (bus.tx_byte_num !== 16'd1024) begin failures++; $display("FAIL full_byte_num got=%0d exp=1024", bus.tx_byte_num); end
    for (int i = 0; i < 256; i++) begin
      req(w); e = exp_q.pop_front();
      checks++; if (w !== e) begin failures++; $display("FAIL full_word%0d got=%h exp=%h", i, w, e); end
    end
    done_pkt();
  endtask

  task automatic test_overflow();
    int o0; logic ok; logic [31:0] w, e;
    exp_q.push_back(32'h12345678);
    hw(16'h1234, 0); hw(16'h5678, 1);
    wait_start(ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_start_timeout got=0 exp=1"); end
    o0 = ovf_cnt;
    bus.data_en_16 = 1'b1; bus.data_16 = 16'h5555;
    @(negedge eth_tx_clk);
    bus.data_en_16 = 1'b0;
    @(negedge eth_tx_clk);
    checks++; if (ovf_cnt !== o0 + 1) begin failures++; $display("FAIL ovf_pulses got=%0d exp=1", ovf_cnt - o0); end
    req(w); e = exp_q.pop_front();
    checks++; if (w !== e) begin failures++; $display("FAIL ovf_word got=%h exp=%h", w, e); end
    done_pkt();
    exp_q.push_back(32'h99990000);
    exp_q.push_back(32'h00000000);
    hw(16'h9999, 1);
    wait_start(ok);
    checks++; if (bus.tx_byte_num !== 16'd2) begin failures++; $display("FAIL ovf_next_byte_num got=%0d exp=2", bus.tx_byte_num); end
    for (int i = 0; i < 2; i++) begin
      req(w); e = exp_q.pop_front();
      checks++; if (w !== e) begin failures++; $display("FAIL ovf_next_word%0d got=%h exp=%h", i, w, e); end
    end
    done_pkt();
  endtask

  task automatic test_reset_mid_fill();
    int s0; logic ok; logic [31:0] w, e;
    s0 = start_cnt;
    hw(16'hDEAD, 0); hw(16'hBEEF, 0); hw(16'hCAFE, 0);
    rst = 1'b1;
    @(negedge eth_tx_clk);
    rst = 1'b0;
    repeat (3) @(negedge eth_tx_clk);
    checks++; if (start_cnt !== s0) begin failures++; $display("FAIL rst_no_start got=%0d exp=0", start_cnt - s0); end
    checks++; if (bus.data_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.data_ready); end
    exp_q.push_back(32'h01020304);
    hw(16'h0102, 0); hw(16'h0304, 1);
    wait_start(ok);
    checks++; if (bus.tx_byte_num !== 16'd4) begin failures++; $display("FAIL rst_byte_num got=%0d exp=4", bus.tx_byte_num); end
    req(w); e = exp_q.pop_front();
    checks++; if (w !== e) begin failures++; $display("FAIL rst_word got=%h exp=%h", w, e); end
    done_pkt();
  endtask

  task automatic test_single();
    logic ok; logic [31:0] w, e;
    exp_q.push_back(32'h00FF0000);
    hw(16'h00FF, 1);
    wait_start(ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_start_timeout got=0 exp=1"); end
    checks++; if (bus.tx_byte_num !== 16'd2) begin failures++; $display("FAIL single_byte_num got=%0d exp=2", bus.tx_byte_num); end
    req(w); e = exp_q.pop_front();
    checks++; if (w !== e) begin failures++; $display("FAIL single_word got=%h exp=%h", w, e); end
    done_pkt();
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_full();
    test_overflow();
    test_reset_mid_fill();
    test_single();
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/udp_16_to_32bit.md
Name: udp_16_to_32bit

Overview:
- Transmit-side width converter for the Ethernet/UDP path.
- Accepts a stream of 16-bit halfwords from the local source (SDRAM read port or camera buffer) and packs them into 32-bit words, high half first.
- Buffers one packet and presents it to the UDP transmitter: issues a start pulse with the byte count, then serves 32-bit words on the transmitter's per-word request.
- Sits between the 16-bit data domain logic and the UDP TX module, on eth_tx_clk.

Parameters:
- MAX_WORDS, 256, buffer depth in 32-bit words; a packet closes automatically when full (max 1024 bytes).
- AW, 8, address width of the buffer (log2 of MAX_WORDS).

Ports:
- eth_tx_clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_en_16  input  1  halfword valid.
- data_16  input  16  halfword data.
- data_last  input  1  qualifies the last halfword of a packet; valid only with data_en_16.
- data_ready  output  1  block can accept a halfword this cycle.
- tx_start_en  output  1  one-cycle pulse: the packet is ready.
- tx_byte_num  output  16  packet length in bytes; stable from tx_start_en until udp_tx_done.
- tx_req  input  1  UDP TX requests the next 32-bit word.
- tx_data  output  32  packed word; valid on the cycle after tx_req.
- udp_tx_done  input  1  UDP TX finished sending the packet.
- overflow  output  1  one-cycle pulse: a halfword arrived while data_ready was low and was dropped.

Behaviour:
- Reset values: data_ready=1, tx_start_en=0, tx_byte_num=0, tx_data=0, overflow=0.
  - Reset also clears the state to IDLE, empties the buffer and clears the half flag.
  - Reset mid-packet abandons the packet; no tx_start_en is issued.
- States:
  - IDLE: data_ready=1; the first data_en_16 moves to FILL.
  - FILL: data_ready=1.
  - START: data_ready=0; tx_start_en=1 for exactly one cycle, then SEND.
  - SEND: data_ready=0.
- Packing:
  - The first halfword of a pair goes to the hold register [31:16].
  - The second halfword goes to [15:0], and the 32-bit word is written to the buffer at wr_ptr in that cycle.
  - Halfword count hcnt increments on every accepted halfword.
- Packet close: FILL goes to START, from the close cycle, when either:
  - data_last is accepted, or
  - hcnt reaches 2*MAX_WORDS.
- Odd length: if close happens with only a high half held, that word is written with [15:0]=0.
  - tx_byte_num = 2*hcnt, the true byte count, not rounded up.
- A single halfword with data_last from IDLE is a complete packet: 2 bytes, one word.
- Read path:
  - Each tx_req in SEND reads buffer[rd_ptr] into tx_data on the next cycle, and rd_ptr increments.
  - Read latency is exactly 1 cycle.
  - tx_req beyond the stored word count: tx_data=0 and rd_ptr holds.
  - tx_req outside SEND is ignored; tx_data holds.
- Completion: udp_tx_done in SEND returns to IDLE.
  - Pointers and hcnt clear; tx_byte_num holds its last value.
  - data_ready rises in the cycle after udp_tx_done.
  - udp_tx_done outside SEND is ignored.
- Simultaneous events:
  - data_en_16 with data_ready low: data dropped, overflow pulses, no state change.
  - tx_req and udp_tx_done in the same cycle: the read is performed, then IDLE.
- Widths: hcnt is AW+2 bits; tx_byte_num is zero-extended to 16.

Test Plan:
- Even packet: four halfwords 0x1111, 0x2222, 0x3333, 0x4444 (last on 4th) -> tx_start_en one pulse, tx_byte_num=8; two tx_req -> tx_data 0x11112222 then 0x33334444, each one cycle after its tx_req; udp_tx_done -> data_ready=1 next cycle.
- Odd packet: 0xAAAA, 0xBBBB, 0xCCCC (last) -> tx_byte_num=6; words 0xAAAABBBB, 0xCCCC0000; third tx_req -> tx_data=0.
- Full close: 2*MAX_WORDS halfwords with no data_last -> tx_start_en after the 512th halfword, tx_byte_num=1024; all 256 words read back in order.
- Overflow: drive data_en_16=0x5555 during SEND -> overflow pulses once; the packet contents are unchanged; the next packet after udp_tx_done does not contain 0x5555.
- Reset mid-FILL: three halfwords, then rst for one cycle -> no tx_start_en; a new 2-halfword packet 0x0102, 0x0304 gives tx_byte_num=4 and tx_data 0x01020304.
- Single halfword: 0x00FF with data_last from IDLE -> tx_byte_num=2; tx_data=0x00FF0000.
